// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with a shadow register,
// anode guard time, per-digit decimal points and leading-zero suppression.
module seven_seg_mux_driver #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 1,
    parameter int HEX_MODE    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   load,
    input  logic                   blank,
    input  logic                   lz_en,
    output logic [NDIGITS-1:0]     an,
    output logic [7:1]             seg,
    output logic                   dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

    logic [4*NDIGITS-1:0] shadow_digits;
    logic [NDIGITS-1:0]   shadow_dp;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;

    logic [3:0]           cur_val;
    logic                 cur_dp;
    logic                 upper_zero;
    logic                 suppressed;
    logic                 active;
    logic [NDIGITS-1:0]   an_next;
    logic [7:1]           seg_next;
    logic                 dp_next;

    // Active-low a..g; values 10..15 go blank when only BCD is wanted.
    function automatic logic [7:1] decode(input logic [3:0] v);
        logic [7:1] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && v > 4'd9) s = 7'b1111111;
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
        end else if (load) begin
            shadow_digits <= digits;
            shadow_dp     <= dp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        cur_val    = shadow_digits[int'(idx)*4 +: 4];
        cur_dp     = shadow_dp[int'(idx)];
        upper_zero = 1'b1;
        suppressed = 1'b0;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (shadow_digits[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) suppressed = lz_en && upper_zero;
        end
        active = (cnt >= GUARD_END) && !blank && !suppressed;
        for (int i = 0; i < NDIGITS; i++) begin
            an_next[i] = !(active && idx == IDX_W'(i));
        end
        seg_next = active ? decode(cur_val) : 7'b1111111;
        dp_next  = active ? ~cur_dp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
